// File: rtl/wrd_pkg.sv
// Shared sizing constants and FSM state encoding for the FC parameter streamer.
package wrd_pkg;

    localparam int WRD_I_BW        = 8;
    localparam int WRD_BIAS_BW     = WRD_I_BW * 2;
    localparam int WRD_NUM_CLASSES = 3;
    localparam int WRD_DEPTH       = 208;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/fc_weight_mem.sv
// Weight storage: one synchronous write port and one registered read port with
// read enable. The read register doubles as the streamer's prefetch stage.
module fc_weight_mem #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 208,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Addresses past DEPTH-1 exist when DEPTH is not a power of two; drop them.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH)))
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fc_param_streamer.sv
// Streams one packet of DEPTH weight words plus a constant bias word per start
// request, with valid/ready handshaking and a prefetch stage hiding read latency.
module fc_param_streamer
    import wrd_pkg::*;
#(
    parameter int I_BW        = WRD_I_BW,
    parameter int BIAS_BW     = I_BW * 2,
    parameter int NUM_CLASSES = WRD_NUM_CLASSES,
    parameter int DEPTH       = WRD_DEPTH,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [AW-1:0]                  wr_addr_i,
    input  logic [NUM_CLASSES*I_BW-1:0]    wr_data_i,
    input  logic                           bias_wr_en_i,
    input  logic [NUM_CLASSES*BIAS_BW-1:0] bias_data_i,
    input  logic                           start_i,
    output logic [NUM_CLASSES*I_BW-1:0]    data_w_o,
    output logic [NUM_CLASSES*BIAS_BW-1:0] data_b_o,
    output logic                           valid_o,
    output logic                           last_o,
    input  logic                           ready_i,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int          WW        = NUM_CLASSES * I_BW;
    localparam int          BW        = NUM_CLASSES * BIAS_BW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t          state;
    logic [BW-1:0]   bias_reg;
    logic [AW-1:0]   fetch_addr;
    logic            fetch_done;
    logic [WW-1:0]   word_p0;
    logic            vld_p0;
    logic            last_p0;

    logic            wr_ok;
    logic            bias_ok;
    logic            accept;
    logic            accept_last;
    logic            load_out;
    logic            fetch_phase;
    logic            rd_en;

    assign wr_ok       = wr_en_i && !busy_o;
    assign bias_ok     = bias_wr_en_i && !busy_o;
    assign accept      = valid_o && ready_i;
    assign accept_last = accept && last_o;
    assign load_out    = vld_p0 && (!valid_o || ready_i);

    // A held start in DONE prefetches address 0 early so back-to-back packets
    // are separated by only the DONE and PRIME cycles.
    assign fetch_phase = (state == ST_PRIME) || (state == ST_STREAM) ||
                         ((state == ST_DONE) && start_i);
    assign rd_en       = fetch_phase && !fetch_done && (!vld_p0 || load_out);

    fc_weight_mem #(
        .WIDTH (WW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk_i),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_en   (rd_en),
        .rd_addr (fetch_addr),
        .rd_data (word_p0)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bias_reg <= '0;
        end else if (bias_ok) begin
            bias_reg <= bias_data_i;
        end
    end

    // data_b_o is the packet bias register itself, latched once in PRIME.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            data_b_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state  <= ST_PRIME;
                        busy_o <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    state    <= ST_STREAM;
                    data_b_o <= bias_reg;
                end
                ST_STREAM: begin
                    if (accept_last) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start_i) begin
                        state <= ST_PRIME;
                    end else begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Fetch counter saturates at DEPTH-1; fetch_done stops further reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_addr <= '0;
            fetch_done <= 1'b0;
            vld_p0     <= 1'b0;
            last_p0    <= 1'b0;
        end else begin
            if (accept_last) begin
                fetch_addr <= '0;
                fetch_done <= 1'b0;
            end else if (rd_en) begin
                if (fetch_addr == LAST_ADDR)
                    fetch_done <= 1'b1;
                else
                    fetch_addr <= fetch_addr + 1'b1;
            end

            if (rd_en) begin
                vld_p0  <= 1'b1;
                last_p0 <= (fetch_addr == LAST_ADDR);
            end else if (load_out) begin
                vld_p0  <= 1'b0;
            end
        end
    end

    // Output stage: refilled from the prefetch stage whenever empty or accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            data_w_o <= '0;
        end else if (load_out) begin
            valid_o  <= 1'b1;
            last_o   <= last_p0;
            data_w_o <= word_p0;
        end else if (accept) begin
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fc_param_streamer.sv
// Directed self-checking bench for fc_param_streamer with DEPTH=8 and a
// known weight pattern: word at address a = {a+2, a+1, a}.
module tb_fc_param_streamer;

    localparam int I_BW        = 8;
    localparam int BIAS_BW     = 16;
    localparam int NUM_CLASSES = 3;
    localparam int DEPTH       = 8;
    localparam int AW          = 3;
    localparam int WW          = NUM_CLASSES * I_BW;
    localparam int BW          = NUM_CLASSES * BIAS_BW;
    localparam logic [BW-1:0] BIAS_V = {16'd300, 16'hFFFB, 16'd7};

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          bias_wr_en;
    logic [BW-1:0] bias_data;
    logic          start;
    logic [WW-1:0] data_w;
    logic [BW-1:0] data_b;
    logic          valid;
    logic          last;
    logic          ready;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WW-1:0] cap_w [16];
    logic          cap_l [16];
    logic [BW-1:0] cap_b [16];
    int cap_n, stall_bad, stall_cnt, first_valid, last_acc_c, done_c;

    fc_param_streamer #(
        .I_BW        (I_BW),
        .BIAS_BW     (BIAS_BW),
        .NUM_CLASSES (NUM_CLASSES),
        .DEPTH       (DEPTH),
        .AW          (AW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .bias_wr_en_i (bias_wr_en),
        .bias_data_i  (bias_data),
        .start_i      (start),
        .data_w_o     (data_w),
        .data_b_o     (data_b),
        .valid_o      (valid),
        .last_o       (last),
        .ready_i      (ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] exp_word(input int a);
        return {8'(a + 2), 8'(a + 1), 8'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all();
        for (int a = 0; a < DEPTH; a++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(a);
            wr_data = exp_word(a);
            tick();
        end
        wr_en      = 1'b0;
        bias_wr_en = 1'b1;
        bias_data  = BIAS_V;
        tick();
        bias_wr_en = 1'b0;
    endtask

    // Records accepted beats from the cycle after the start edge (c=0) until
    // done_o, optionally toggling ready and injecting a write+start at beat 4.
    task automatic capture(input bit alt_ready, input bit inject);
        logic [WW-1:0] sv_w;
        logic [BW-1:0] sv_b;
        logic          sv_l;
        bit            stall_pend;
        cap_n = 0; stall_bad = 0; stall_cnt = 0;
        first_valid = -1; last_acc_c = -1; done_c = -1;
        stall_pend = 1'b0;
        sv_w = '0; sv_b = '0; sv_l = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (stall_pend && (valid !== 1'b1 || data_w !== sv_w ||
                               last !== sv_l || data_b !== sv_b))
                stall_bad++;
            stall_pend = 1'b0;
            if (done === 1'b1) begin
                done_c = c;
                break;
            end
            ready = alt_ready ? ((c % 2) == 0) : 1'b1;
            wr_en = 1'b0;
            start = 1'b0;
            if (inject && valid === 1'b1 && cap_n == 4) begin
                wr_en   = 1'b1;
                wr_addr = 3'd2;
                wr_data = '0;
                start   = 1'b1;
            end
            if (valid === 1'b1) begin
                if (first_valid < 0) first_valid = c;
                if (ready) begin
                    if (cap_n < 16) begin
                        cap_w[cap_n] = data_w;
                        cap_l[cap_n] = last;
                        cap_b[cap_n] = data_b;
                    end
                    cap_n++;
                    last_acc_c = c;
                end else begin
                    sv_w = data_w; sv_l = last; sv_b = data_b;
                    stall_pend = 1'b1;
                    stall_cnt++;
                end
            end
            tick();
        end
        wr_en = 1'b0;
        start = 1'b0;
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bias_wr_en = 1'b0; bias_data = '0; start = 1'b0; ready = 1'b1;
        tick(); tick();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (data_w !== '0) begin n_fail++; $display("FAIL reset_data_w: got %h expected 0", data_w); end
        n_checks++; if (data_b !== '0) begin n_fail++; $display("FAIL reset_data_b: got %h expected 0", data_b); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stream_busy_prime: got %b expected 1", busy); end
        capture(1'b0, 1'b0);
        n_checks++; if (cap_n !== 8) begin n_fail++; $display("FAIL stream_beats: got %0d expected 8", cap_n); end
        n_checks++; if (first_valid !== 2) begin n_fail++; $display("FAIL stream_latency: got %0d expected 2", first_valid); end
        n_checks++; if (last_acc_c !== 9) begin n_fail++; $display("FAIL stream_no_bubbles: last beat at %0d expected 9", last_acc_c); end
        n_checks++; if (done_c !== 10) begin n_fail++; $display("FAIL stream_done: got cycle %0d expected 10", done_c); end
        for (int b = 0; b < 8; b++) begin
            n_checks++; if (cap_w[b] !== exp_word(b)) begin n_fail++; $display("FAIL stream_word beat %0d: got %h expected %h", b, cap_w[b], exp_word(b)); end
            n_checks++; if (cap_l[b] !== (b == 7)) begin n_fail++; $display("FAIL stream_last beat %0d: got %b expected %b", b, cap_l[b], (b == 7)); end
            n_checks++; if (cap_b[b] !== BIAS_V) begin n_fail++; $display("FAIL stream_bias beat %0d: got %h expected %h", b, cap_b[b], BIAS_V); end
        end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stream_done_pulse: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_stall();
        start = 1'b1;
        tick();
        start = 1'b0;
        capture(1'b1, 1'b0);
        n_checks++; if (cap_n !== 8) begin n_fail++; $display("FAIL stall_beats: got %0d expected 8", cap_n); end
        n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", stall_bad); end
        n_checks++; if (stall_cnt !== 7) begin n_fail++; $display("FAIL stall_count: got %0d expected 7", stall_cnt); end
        n_checks++; if (done_c !== 17) begin n_fail++; $display("FAIL stall_done: got cycle %0d expected 17", done_c); end
        for (int b = 0; b < 8; b++) begin
            n_checks++; if (cap_w[b] !== exp_word(b)) begin n_fail++; $display("FAIL stall_word beat %0d: got %h expected %h", b, cap_w[b], exp_word(b)); end
            n_checks++; if (cap_l[b] !== (b == 7)) begin n_fail++; $display("FAIL stall_last beat %0d: got %b expected %b", b, cap_l[b], (b == 7)); end
        end
        tick();
    endtask

    task automatic test_ignore_busy();
        start = 1'b1;
        tick();
        start = 1'b0;
        capture(1'b0, 1'b1);
        n_checks++; if (cap_n !== 8) begin n_fail++; $display("FAIL busy_beats: got %0d expected 8", cap_n); end
        for (int b = 0; b < 8; b++) begin
            n_checks++; if (cap_w[b] !== exp_word(b)) begin n_fail++; $display("FAIL busy_word beat %0d: got %h expected %h", b, cap_w[b], exp_word(b)); end
        end
        tick(); tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_queue: got %b expected 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL busy_no_queue_valid: got %b expected 0", valid); end
        start = 1'b1;
        tick();
        start = 1'b0;
        capture(1'b0, 1'b0);
        n_checks++; if (cap_w[2] !== exp_word(2)) begin n_fail++; $display("FAIL busy_write_ignored: got %h expected %h", cap_w[2], exp_word(2)); end
        tick();
    endtask

    task automatic test_write_start();
        wr_en   = 1'b1;
        wr_addr = 3'd5;
        wr_data = 24'hA55A3C;
        start   = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        capture(1'b0, 1'b0);
        n_checks++; if (first_valid !== 2) begin n_fail++; $display("FAIL wrstart_latency: got %0d expected 2", first_valid); end
        for (int b = 0; b < 8; b++) begin
            n_checks++;
            if (cap_w[b] !== ((b == 5) ? 24'hA55A3C : exp_word(b))) begin
                n_fail++;
                $display("FAIL wrstart_word beat %0d: got %h expected %h", b, cap_w[b], (b == 5) ? 24'hA55A3C : exp_word(b));
            end
        end
        tick();
        wr_en   = 1'b1;
        wr_addr = 3'd5;
        wr_data = exp_word(5);
        tick();
        wr_en = 1'b0;
    endtask

    // Three packets expected: beats at c=2..9, 12..19, 22..29; DONE at 10, 20, 30.
    task automatic test_back_to_back();
        int  pos;
        bit  exp_v;
        ready = 1'b1;
        start = 1'b1;
        tick();
        for (int c = 0; c < 40; c++) begin
            pos   = (c - 2) % 10;
            exp_v = (c >= 2) && (c <= 29) && (pos < 8);
            n_checks++; if (valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, valid, exp_v); end
            n_checks++; if (done !== (c == 10 || c == 20 || c == 30)) begin n_fail++; $display("FAIL b2b_done c=%0d: got %b expected %b", c, done, (c == 10 || c == 20 || c == 30)); end
            if (exp_v) begin
                n_checks++; if (data_w !== exp_word(pos)) begin n_fail++; $display("FAIL b2b_word c=%0d: got %h expected %h", c, data_w, exp_word(pos)); end
                n_checks++; if (last !== (pos == 7)) begin n_fail++; $display("FAIL b2b_last c=%0d: got %b expected %b", c, last, (pos == 7)); end
            end
            if (c == 29) start = 1'b0;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        n_checks++; if (valid !== 1'b1 || data_w !== exp_word(3)) begin n_fail++; $display("FAIL rstmid_beat3: got v=%b %h expected v=1 %h", valid, data_w, exp_word(3)); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_valid: got %b expected 0", valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_busy: got %b expected 0", busy); end
        n_checks++; if (data_b !== '0) begin n_fail++; $display("FAIL rstmid_async_bias: got %h expected 0", data_b); end
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        capture(1'b0, 1'b0);
        n_checks++; if (cap_n !== 8) begin n_fail++; $display("FAIL rstmid_beats: got %0d expected 8", cap_n); end
        for (int b = 0; b < 8; b++) begin
            n_checks++; if (cap_w[b] !== exp_word(b)) begin n_fail++; $display("FAIL rstmid_word beat %0d: got %h expected %h", b, cap_w[b], exp_word(b)); end
            n_checks++; if (cap_b[b] !== '0) begin n_fail++; $display("FAIL rstmid_bias beat %0d: got %h expected 0", b, cap_b[b]); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        load_all();
        test_stream();
        test_stall();
        test_ignore_busy();
        test_write_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
